// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code receive monitor.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } gray_state_e;

    localparam int                  ERRCNT_W   = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_SAT = 8'd255;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_rx_monitor.sv
// Gray-code sample monitor: decodes, checks sequence continuity, flags wrap and sequence errors.
// Optional saturating error counter enabled by defining GRAY_RX_ERRCNT_EN.
module gray_rx_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                In_valid,
    input  logic [WIDTH-1:0]    Gray_in,
    output logic                Out_valid,
    output logic [WIDTH-1:0]    Binary,
    output logic                Locked,
    output logic                Wrap,
    output logic                Seq_err,
    output logic [ERRCNT_W-1:0] Err_count
);

    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    gray_state_e      state_q, state_d;
    logic [WIDTH-1:0] last_bin_q, last_bin_d;
    logic [WIDTH-1:0] dec_s, next_bin_s;
    logic             out_valid_q, out_valid_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             seq_err_q, seq_err_d;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray_i (Gray_in),
        .bin_o  (dec_s)
    );

    assign next_bin_s = last_bin_q + BIN_ONE;

    // Next-state, accepted value and flag computation
    always_comb begin
        state_d     = state_q;
        last_bin_d  = last_bin_q;
        out_valid_d = 1'b0;
        seq_err_d   = 1'b0;
        wrap_d      = wrap_q;
        if (In_valid) begin
            case (state_q)
                TRACK: begin
                    if (dec_s == last_bin_q) begin
                        out_valid_d = 1'b1;
                    end else if (dec_s == next_bin_s) begin
                        last_bin_d  = dec_s;
                        out_valid_d = 1'b1;
                        if (last_bin_q == BIN_MAX) begin
                            wrap_d = 1'b1;
                        end else begin
                            wrap_d = wrap_q;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ERR;
                    end
                end
                IDLE, ERR: begin
                    // fresh lock and post-error resync take the sample as the new reference
                    last_bin_d  = dec_s;
                    out_valid_d = 1'b1;
                    state_d     = TRACK;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == TRACK);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            last_bin_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_bin_q  <= last_bin_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            wrap_q      <= wrap_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign Out_valid = out_valid_q;
    assign Binary    = last_bin_q;
    assign Locked    = locked_q;
    assign Wrap      = wrap_q;
    assign Seq_err   = seq_err_q;

`ifdef GRAY_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    // Saturating error counter, advanced alongside each sequence error
    always_comb begin
        if (seq_err_d && (err_count_q != ERRCNT_SAT)) begin
            err_count_d = err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_count_q <= {ERRCNT_W{1'b0}};
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign Err_count = err_count_q;
`else
    assign Err_count = {ERRCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Self-checking bench for gray_rx_monitor against a behavioural sequence model.
module tb_gray_rx_monitor;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;
    localparam int VW   = W + 12;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         In_valid = 1'b0;
    logic [W-1:0] Gray_in = '0;
    logic         Out_valid;
    logic [W-1:0] Binary;
    logic         Locked;
    logic         Wrap;
    logic         Seq_err;
    logic [7:0]   Err_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_trk, m_wrap, m_ov, m_se;
    int m_last, m_errs;

    gray_rx_monitor #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .Gray_in   (Gray_in),
        .Out_valid (Out_valid),
        .Binary    (Binary),
        .Locked    (Locked),
        .Wrap      (Wrap),
        .Seq_err   (Seq_err),
        .Err_count (Err_count)
    );

    always #5 Clk = ~Clk;

    function automatic int dec(input int g);
        int d = 0;
        for (int i = 0; i < W; i++) d = d ^ (g >> i);
        return d & MAXV;
    endfunction

    function automatic int enc(input int b);
        return (b ^ (b >> 1)) & MAXV;
    endfunction

    task automatic m_reset();
        m_trk = 1'b0; m_wrap = 1'b0; m_ov = 1'b0; m_se = 1'b0;
        m_last = 0; m_errs = 0;
    endtask

    task automatic m_step(input bit v, input int g);
        int d;
        m_ov = 1'b0;
        m_se = 1'b0;
        if (v) begin
            d = dec(g);
            if (!m_trk) begin
                m_last = d; m_ov = 1'b1; m_trk = 1'b1;
            end else if (d == m_last) begin
                m_ov = 1'b1;
            end else if (d == ((m_last + 1) % (MAXV + 1))) begin
                if (m_last == MAXV) m_wrap = 1'b1;
                m_last = d; m_ov = 1'b1;
            end else begin
                m_se = 1'b1; m_trk = 1'b0; m_errs++;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        int ec;
`ifdef GRAY_RX_ERRCNT_EN
        ec = (m_errs > 255) ? 255 : m_errs;
`else
        ec = 0;
`endif
        return {m_ov, W'(m_last), m_trk, m_wrap, m_se, 8'(ec)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {Out_valid, Binary, Locked, Wrap, Seq_err, Err_count};
    endfunction

    // one clock with the given input; outputs sampled 1 time unit after the edge
    task automatic cyc(input bit v, input int g);
        In_valid = v;
        Gray_in  = W'(g);
        @(posedge Clk);
        #1;
        m_step(v, g);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            In_valid = 1'b1;
            Gray_in  = W'($urandom_range(MAXV));
            @(posedge Clk);
            #1;
            total++;
            if (obs_vec() !== {VW{1'b0}}) begin
                bad++;
                $display("FAIL reset_hold: got %h want %h", obs_vec(), {VW{1'b0}});
            end
        end
        In_valid = 1'b0;
        Reset = 1'b1;
        m_reset();
        cyc(1'b0, 0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full_cycle();
        int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        int bseq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, gseq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL full_cycle_model step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
            if (Binary !== W'(bseq[i]) || Out_valid !== 1'b1 || Seq_err !== 1'b0 || Locked !== 1'b1
                || Wrap !== (i == 8)) begin
                bad++;
                $display("FAIL full_cycle step %0d: got bin=%0d ov=%b se=%b lk=%b wr=%b want bin=%0d ov=1 se=0 lk=1 wr=%0d",
                         i, Binary, Out_valid, Seq_err, Locked, Wrap, bseq[i], (i == 8));
            end
        end
    endtask

    task automatic test_repeat_idle();
        int gseq[6] = '{1, 1, 0, 0, 0, 3};
        bit vseq[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int bseq[6] = '{1, 1, 1, 1, 1, 2};
        for (int i = 0; i < 6; i++) begin
            cyc(vseq[i], gseq[i]);
            total++;
            if (obs_vec() !== exp_vec() || Binary !== W'(bseq[i]) || Out_valid !== vseq[i] || Seq_err !== 1'b0) begin
                bad++;
                $display("FAIL repeat_idle step %0d: got %h (bin=%0d ov=%b) want %h (bin=%0d ov=%b)",
                         i, obs_vec(), Binary, Out_valid, exp_vec(), bseq[i], vseq[i]);
            end
        end
    endtask

    task automatic test_skip_error();
        cyc(1'b1, 3'b011);
        cyc(1'b1, 3'b110);
        total++;
        if (Seq_err !== 1'b1 || Binary !== W'(2) || Locked !== 1'b0 || Out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL skip_err: got se=%b bin=%0d lk=%b ov=%b want se=1 bin=2 lk=0 ov=0", Seq_err, Binary, Locked, Out_valid);
        end
        cyc(1'b1, 3'b111);
        total++;
        if (Seq_err !== 1'b0 || Binary !== W'(5) || Locked !== 1'b1 || Out_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL skip_resync: got se=%b bin=%0d lk=%b ov=%b want se=0 bin=5 lk=1 ov=1", Seq_err, Binary, Locked, Out_valid);
        end
        cyc(1'b1, 3'b101);
        total++;
        if (Binary !== W'(6) || Seq_err !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL skip_next: got bin=%0d se=%b want bin=6 se=0", Binary, Seq_err);
        end
    endtask

    task automatic test_backward();
        cyc(1'b1, 3'b010);
        cyc(1'b1, 3'b010);
        total++;
        if (Binary !== W'(3) || Locked !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL back_lock: got bin=%0d lk=%b want bin=3 lk=1", Binary, Locked);
        end
        cyc(1'b1, 3'b011);
        total++;
        if (Seq_err !== 1'b1 || Locked !== 1'b0 || Binary !== W'(3) || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL back_err: got se=%b lk=%b bin=%0d want se=1 lk=0 bin=3", Seq_err, Locked, Binary);
        end
    endtask

    task automatic test_async_reset();
        int gseq[4] = '{3'b011, 3'b010, 3'b110, 3'b111};
        for (int i = 0; i < 4; i++) cyc(1'b1, gseq[i]);
        In_valid = 1'b0;
        total++;
        if (Binary !== W'(5) || Wrap !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL pre_reset: got bin=%0d wr=%b want bin=5 wr=1", Binary, Wrap);
        end
        #3;
        Reset = 1'b0;
        #1;
        total++;
        if (obs_vec() !== {VW{1'b0}}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), {VW{1'b0}});
        end
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        m_reset();
        cyc(1'b1, 3'b110);
        total++;
        if (Binary !== W'(4) || Seq_err !== 1'b0 || Out_valid !== 1'b1 || Wrap !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset: got bin=%0d se=%b ov=%b wr=%b want bin=4 se=0 ov=1 wr=0", Binary, Seq_err, Out_valid, Wrap);
        end
    endtask

    task automatic test_random();
        int r, b;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(9);
            if (r < 2)      b = m_last;
            else if (r < 7) b = (m_last + 1) % (MAXV + 1);
            else            b = $urandom_range(MAXV);
            cyc(($urandom_range(4) != 0), enc(b));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 310; i++) begin
            cyc(1'b1, enc(0));
            cyc(1'b1, enc(4));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sat step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        total++;
`ifdef GRAY_RX_ERRCNT_EN
        if (Err_count !== 8'd255) begin
            bad++;
            $display("FAIL err_count_sat: got %0d want 255", Err_count);
        end
`else
        if (Err_count !== 8'd0) begin
            bad++;
            $display("FAIL err_count_off: got %0d want 0", Err_count);
        end
`endif
    endtask

    initial begin
        m_reset();
        #1;
        test_reset();
        test_full_cycle();
        test_repeat_idle();
        test_skip_error();
        test_backward();
        test_async_reset();
        test_random();
        test_err_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
